// File: rtl/sd_spi_master.sv
// SPI mode-0 byte initiator for the SD card lines, with slow/fast clock rates and software chip select.
// Optional activity indicator enabled by defining SD_SPI_ACT_EN.
module sd_spi_master #(
  parameter int DIV_SLOW = 124,
  parameter int DIV_FAST = 1
`ifdef SD_SPI_ACT_EN
  ,
  parameter int ACT_TIMEOUT = 2000000
`endif
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_wr,
  input  logic       cs_val,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  input  logic       miso,
  output logic       act
);

  localparam int DMAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DW   = (DMAX < 1) ? 1 : $clog2(DMAX + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [DW-1:0]   lim_q, lim_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      tx_q, tx_d;
  logic [7:0]      rxsh_q, rxsh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ss_q, ss_d;
  logic            busy_w;
  logic            accept_w;

  assign busy_w   = (state_q == LOW) || (state_q == HIGH);
  assign accept_w = start && !busy_w;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      lim_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rxsh_q    <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      ss_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      lim_q     <= lim_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rxsh_q    <= rxsh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    lim_d     = lim_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rxsh_d    = rxsh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;

    case (state_q)
      // FIN accepts a new start too, so bytes can run back to back.
      IDLE, FIN: begin
        state_d = IDLE;
        if (accept_w) begin
          tx_d    = tx_data[6:0];
          lim_d   = fast ? DW'(DIV_FAST) : DW'(DIV_SLOW);
          mosi_d  = tx_data[7];
          bit_d   = '0;
          div_d   = '0;
          rxsh_d  = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_q == lim_q) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rxsh_d  = {rxsh_q[6:0], miso};
          state_d = HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_q == lim_q) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            rx_data_d = rxsh_q;
            mosi_d    = 1'b1;
            state_d   = FIN;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = tx_q[6];
            tx_d    = {tx_q[5:0], 1'b0};
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (cs_wr && !busy_w) begin
      ss_d = cs_val;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_w;
  assign done    = (state_q == FIN);
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss      = ss_q;

`ifdef SD_SPI_ACT_EN
  localparam int AW = $clog2(ACT_TIMEOUT + 1);

  logic [AW-1:0] act_q;
  logic          mosi_prev_q;
  logic          miso_prev_q;

  // Any accepted start or line toggle restarts the stretch window.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      act_q       <= AW'(ACT_TIMEOUT);
      mosi_prev_q <= 1'b1;
      miso_prev_q <= 1'b1;
    end else begin
      mosi_prev_q <= mosi_q;
      miso_prev_q <= miso;
      if (accept_w || (mosi_q != mosi_prev_q) || (miso != miso_prev_q)) begin
        act_q <= '0;
      end else if (act_q < AW'(ACT_TIMEOUT)) begin
        act_q <= act_q + AW'(1);
      end
    end
  end

  assign act = (act_q < AW'(ACT_TIMEOUT));
`else
  assign act = 1'b0;
`endif

endmodule
